// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and LS word requests onto a byte-wide bus.
// Optional MEM_CTRL_IO_STALL_EN holds IO-region stores while io_buffer_full.
module mem_ctrl #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_HI  = 2'b11
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clr_in,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      IF_RD,
      LS_RD,
      LS_WR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       buf_q;
   logic [31:0]       buf_nx;
   logic [2:0]        n_q;
   logic [2:0]        cnt;
   logic              wr_q;
   logic              stall;
   logic              io_hit;
   logic              last;
   logic [1:0]        idx;
   logic [7:0]        wbyte;

   // Size 3 is illegal and handled as a full word.
   function automatic logic [2:0] nbytes(input logic [1:0] s);
      case (s)
         2'd0:    nbytes = 3'd1;
         2'd1:    nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   endfunction

   assign io_hit = (mem_a[17:16] == IO_HI);

`ifdef MEM_CTRL_IO_STALL_EN
   assign stall = (state == LS_WR) && (cnt != 3'd0)
                  && io_hit && io_buffer_full;
`else
   logic unused_io;
   assign unused_io = io_buffer_full & io_hit;
   assign stall = 1'b0;
`endif

   // cnt is 1..n while byte cnt-1 is on the bus.
   assign idx   = cnt[1:0] - 2'd1;
   assign last  = (cnt == n_q);
   assign wbyte = wdata_q[{cnt[1:0], 3'b000} +: 8];

   // Pausing or an IO stall suppresses the strobe so no byte is repeated.
   assign mem_wr = wr_q & rdy_in & ~stall;
   assign busy   = (state != IDLE);

   // Merge the byte on mem_din into its lane of the read buffer.
   always_comb begin
      buf_nx = buf_q;
      buf_nx[{idx, 3'b000} +: 8] = mem_din;
   end

   // Arbitration and byte sequencing; everything freezes while rdy_in is low.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         buf_q    <= '0;
         n_q      <= '0;
         cnt      <= '0;
         wr_q     <= 1'b0;
         mem_a    <= '0;
         mem_dout <= '0;
         if_done  <= 1'b0;
         ls_done  <= 1'b0;
         if_data  <= '0;
         ls_rdata <= '0;
      end else begin
         if_done <= 1'b0;
         ls_done <= 1'b0;
         if (rdy_in) begin
            case (state)
               IDLE: begin
                  wr_q  <= 1'b0;
                  cnt   <= '0;
                  buf_q <= '0;
                  if (!if_done && !ls_done) begin
                     if (ls_req) begin
                        addr_q  <= ls_addr;
                        wdata_q <= ls_wdata;
                        n_q     <= nbytes(ls_size);
                        state   <= ls_we ? LS_WR : LS_RD;
                     end else if (if_req && !clr_in) begin
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                        n_q     <= 3'd4;
                        state   <= IF_RD;
                     end
                  end
               end
               default: begin
                  if (state == IF_RD && clr_in) begin
                     state <= IDLE;
                     wr_q  <= 1'b0;
                  end else if (!stall) begin
                     if (cnt != 3'd0 && state != LS_WR)
                        buf_q <= buf_nx;
                     if (last) begin
                        state <= IDLE;
                        wr_q  <= 1'b0;
                        if (state == IF_RD) begin
                           if_done <= 1'b1;
                           if_data <= buf_nx;
                        end else begin
                           ls_done <= 1'b1;
                           if (state == LS_RD)
                              ls_rdata <= buf_nx;
                        end
                     end else begin
                        mem_a    <= addr_q
                                    + {{(ADDR_W-3){1'b0}}, cnt};
                        mem_dout <= wbyte;
                        wr_q     <= (state == LS_WR);
                        cnt      <= cnt + 3'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, corner sequences and random traffic
// checked against a byte-array memory model and an active-edge count.
module tb_mem_ctrl;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        clr_in;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        busy;

   mem_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .clr_in(clr_in), .if_req(if_req), .if_addr(if_addr),
      .if_done(if_done), .if_data(if_data), .ls_req(ls_req),
      .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
      .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .busy(busy)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic [7:0]  ram   [0:65535];
   logic [7:0]  model [0:65535];
   logic [39:0] wlog[$];
   int tests;
   int fails;

   assign mem_din = ram[mem_a[15:0]];

   // Bus-side RAM: records every strobed byte.
   always @(posedge clk_in) begin
      if (mem_wr) begin
         ram[mem_a[15:0]] = mem_dout;
         wlog.push_back({mem_a, mem_dout});
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic int nb(input bit is_if, input logic [1:0] s);
      if (is_if || s >= 2) return 4;
      return (s == 0) ? 1 : 2;
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a,
                                         input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < n; i++)
         r = r | (32'(model[16'(a + 32'(i))]) << (8 * i));
      return r;
   endfunction

   task automatic mstore(input logic [31:0] a, input logic [31:0] d,
                         input int n);
      for (int i = 0; i < n; i++)
         model[16'(a + 32'(i))] = 8'(d >> (8 * i));
   endtask

   // Starts in cycle 0 after the accept edge; done must arrive after
   // exactly n+1 edges with rdy_in high.
   task automatic follow(input bit is_if, input bit we, input int n,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp, input bit rnd,
                         output int cyc);
      int   p;
      bit   seen;
      logic dn;
      p = 0;
      seen = 0;
      cyc = 0;
      wlog.delete();
      while (!seen && cyc < 100) begin
         if (rnd) begin
            rdy_in = ($urandom_range(0, 3) != 0);
            io_buffer_full = ($urandom_range(0, 1) == 1);
            if (!is_if) clr_in = ($urandom_range(0, 1) == 1);
         end
         @(negedge clk_in);
         dn = is_if ? if_done : ls_done;
         if (p >= 1 && p <= n) begin
            chk("bus_addr", mem_a, addr + 32'(p - 1));
            chk("bus_wr", 32'(mem_wr), 32'(we & rdy_in));
            if (we)
               chk("bus_dout", 32'(mem_dout), 32'(8'(wd >> (8 * (p - 1)))));
         end
         if (dn || p == n + 1) begin
            seen = 1;
            chk("done_at", dn ? 32'(p) : 32'hFFFF_FFFF, 32'(n + 1));
            if (!we) chk("rdata", is_if ? if_data : ls_rdata, exp);
         end else begin
            @(posedge clk_in);
            if (rdy_in) p++;
            #1;
            cyc++;
         end
      end
      if (!seen) chk("done_timeout", 32'(cyc), 32'(n + 1));
      if (we) begin
         chk("wlog_len", 32'(wlog.size()), 32'(n));
         for (int i = 0; i < n && i < wlog.size(); i++)
            chk("wlog_ent", wlog[i][39:8] ^ 32'(wlog[i][7:0]),
                (addr + 32'(i)) ^ 32'(8'(wd >> (8 * i))));
      end else begin
         chk("rd_no_wr", 32'(wlog.size()), 32'd0);
      end
   endtask

   task automatic do_txn(input bit is_if, input bit we,
                         input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp,
                         input bit rnd, output int cyc);
      rdy_in = 1'b1;
      clr_in = 1'b0;
      if (is_if) begin
         if_req = 1'b1;
         if_addr = addr;
      end else begin
         ls_req = 1'b1;
         ls_we = we;
         ls_size = sz;
         ls_addr = addr;
         ls_wdata = wd;
      end
      tick();
      follow(is_if, we, nb(is_if, sz), addr, wd, exp, rnd, cyc);
      tick();
      if_req = 1'b0;
      ls_req = 1'b0;
      rdy_in = 1'b1;
      clr_in = 1'b0;
      io_buffer_full = 1'b0;
   endtask

   typedef struct {
      bit          is_if;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int          cyc;
      int          n;
      int          dc;
      bit          isf;
      bit          we;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
      logic        ewr;
      tests = 0;
      fails = 0;
      for (int i = 0; i < 65536; i++) begin
         ram[i] = 8'($urandom);
         model[i] = ram[i];
      end
      a = 32'h9300_0013;
      for (int i = 0; i < 4; i++) ram[16'h100 + 16'(i)] = 8'(a >> (8 * i));
      a = 32'h0000_1237;
      for (int i = 0; i < 4; i++) ram[16'h40 + 16'(i)] = 8'(a >> (8 * i));
      for (int i = 0; i < 4; i++) ram[16'h300 + 16'(i)] = 8'h00;
      ram[16'h10] = 8'h5A;
      ram[16'h11] = 8'hA5;
      for (int i = 0; i < 65536; i++) model[i] = ram[i];

      vecs[0]  = '{1, 0, 2'd2, 32'h100, 32'h0, 32'h9300_0013, 5};
      vecs[1]  = '{0, 0, 2'd0, 32'h010, 32'h0, 32'h0000_005A, 2};
      vecs[2]  = '{0, 0, 2'd1, 32'h010, 32'h0, 32'h0000_A55A, 3};
      vecs[3]  = '{0, 1, 2'd2, 32'h200, 32'hDEAD_BEEF, 32'h0, 5};
      vecs[4]  = '{0, 0, 2'd2, 32'h200, 32'h0, 32'hDEAD_BEEF, 5};
      vecs[5]  = '{0, 1, 2'd0, 32'h201, 32'hAAAA_5577, 32'h0, 2};
      vecs[6]  = '{0, 0, 2'd2, 32'h200, 32'h0, 32'hDEAD_77EF, 5};
      vecs[7]  = '{0, 0, 2'd3, 32'h100, 32'h0, 32'h9300_0013, 5};
      vecs[8]  = '{0, 1, 2'd1, 32'h300, 32'h1234_5678, 32'h0, 3};
      vecs[9]  = '{0, 0, 2'd2, 32'h300, 32'h0, 32'h0000_5678, 5};
      vecs[10] = '{1, 0, 2'd0, 32'h040, 32'h0, 32'h0000_1237, 5};
      vecs[11] = '{0, 0, 2'd1, 32'h102, 32'h0, 32'h0000_9300, 3};

      rst_in = 1'b1;
      rdy_in = 1'b1;
      clr_in = 1'b0;
      if_req = 1'b0;
      if_addr = '0;
      ls_req = 1'b0;
      ls_we = 1'b0;
      ls_size = '0;
      ls_addr = '0;
      ls_wdata = '0;
      io_buffer_full = 1'b0;

      #2 rst_in = 1'b0;
      #1;
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_flags", {28'h0, mem_wr, busy, if_done, ls_done}, 32'h0);
      chk("rst_data", if_data | ls_rdata | 32'(mem_dout), 32'h0);
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_in);
         chk("idle_busy", 32'(busy), 32'h0);
         chk("idle_wr", 32'(mem_wr), 32'h0);
         tick();
      end

      for (int i = 0; i < 12; i++) begin
         do_txn(vecs[i].is_if, vecs[i].we, vecs[i].size, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp, 0, cyc);
         chk("vec_lat", 32'(cyc), 32'(vecs[i].lat));
         if (vecs[i].we)
            mstore(vecs[i].addr, vecs[i].wdata,
                   nb(0, vecs[i].size));
      end

      if_req = 1'b1;
      if_addr = 32'h100;
      ls_req = 1'b1;
      ls_we = 1'b1;
      ls_size = 2'd2;
      ls_addr = 32'h200;
      ls_wdata = 32'hDEAD_BEEF;
      tick();
      follow(0, 1, 4, 32'h200, 32'hDEAD_BEEF, 32'h0, 0, cyc);
      mstore(32'h200, 32'hDEAD_BEEF, 4);
      chk("both_if_idle", 32'(if_done), 32'h0);
      tick();
      ls_req = 1'b0;
      @(negedge clk_in);
      chk("both_gap_busy", 32'(busy), 32'h0);
      tick();
      follow(1, 0, 4, 32'h100, 32'h0, 32'h9300_0013, 0, cyc);
      tick();
      if_req = 1'b0;

      if_req = 1'b1;
      if_addr = 32'h100;
      tick();
      for (int c = 0; c <= 3; c++) begin
         if (c == 2) clr_in = 1'b1;
         if (c == 3) begin
            clr_in = 1'b0;
            if_addr = 32'h40;
         end
         @(negedge clk_in);
         chk("clr_no_done", 32'(if_done), 32'h0);
         if (c == 3) begin
            chk("clr_busy", 32'(busy), 32'h0);
            chk("clr_wr", 32'(mem_wr), 32'h0);
         end else begin
            tick();
         end
      end
      tick();
      follow(1, 0, 4, 32'h40, 32'h0, 32'h0000_1237, 0, cyc);
      tick();
      if_req = 1'b0;

      if_req = 1'b1;
      if_addr = 32'h100;
      clr_in = 1'b1;
      tick();
      @(negedge clk_in);
      chk("clr_idle_busy", 32'(busy), 32'h0);
      clr_in = 1'b0;
      tick();
      follow(1, 0, 4, 32'h100, 32'h0, 32'h9300_0013, 0, cyc);
      tick();
      if_req = 1'b0;

      if_req = 1'b1;
      if_addr = 32'h100;
      tick();
      tick();
      tick();
      clr_in = 1'b1;
      if_req = 1'b0;
      ls_req = 1'b1;
      ls_we = 1'b0;
      ls_size = 2'd0;
      ls_addr = 32'h10;
      tick();
      clr_in = 1'b0;
      @(negedge clk_in);
      chk("abort_ls_busy", 32'(busy), 32'h0);
      chk("abort_no_done", 32'(if_done), 32'h0);
      tick();
      follow(0, 0, 1, 32'h10, 32'h0, 32'h0000_005A, 0, cyc);
      tick();
      ls_req = 1'b0;

`ifdef MEM_CTRL_IO_STALL_EN
      dc = 5;
`else
      dc = 2;
`endif
      ls_req = 1'b1;
      ls_we = 1'b1;
      ls_size = 2'd0;
      ls_addr = 32'h3_0000;
      ls_wdata = 32'h41;
      tick();
      for (int c = 0; c <= 6; c++) begin
         io_buffer_full = (c >= 1 && c <= 3);
         ls_req = (c <= dc);
         ewr = (c == dc - 1);
         @(negedge clk_in);
         chk("io_wr", 32'(mem_wr), 32'(ewr));
         chk("io_done", 32'(ls_done), 32'(c == dc));
         if (ewr) begin
            chk("io_addr", mem_a, 32'h3_0000);
            chk("io_dout", 32'(mem_dout), 32'h41);
         end
         tick();
      end
      io_buffer_full = 1'b0;

      ls_req = 1'b1;
      ls_we = 1'b0;
      ls_size = 2'd1;
      ls_addr = 32'h10;
      exp = mread(32'h10, 2);
      tick();
      for (int c = 0; c <= 8; c++) begin
         rdy_in = !(c >= 2 && c <= 4);
         ls_req = (c <= 6);
         @(negedge clk_in);
         chk("rdy_wr", 32'(mem_wr), 32'h0);
         chk("rdy_done", 32'(ls_done), 32'(c == 6));
         if (c == 1) chk("rdy_a0", mem_a, 32'h10);
         if (c >= 2 && c <= 5) chk("rdy_a_hold", mem_a, 32'h11);
         if (c == 6) chk("rdy_data", ls_rdata, exp);
         tick();
      end
      rdy_in = 1'b1;

      for (int k = 0; k < 60; k++) begin
         isf = ($urandom_range(0, 3) == 0);
         we = isf ? 1'b0 : 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a = 32'($urandom_range(32'h1000, 32'hFFF0));
         wd = $urandom;
         n = nb(isf, sz);
         exp = mread(a, n);
         do_txn(isf, we, sz, a, wd, exp, 1, cyc);
         if (we) mstore(a, wd, n);
      end

      do_txn(0, 0, 2'd2, 32'h100, 32'h0, 32'h9300_0013, 0, cyc);
      ls_req = 1'b1;
      ls_we = 1'b1;
      ls_size = 2'd2;
      ls_addr = 32'h500;
      ls_wdata = 32'hCAFE_F00D;
      tick();
      tick();
      tick();
      #2;
      chk("pre_rst_wr", 32'(mem_wr), 32'h1);
      rst_in = 1'b0;
      #1;
      chk("mid_rst_a", mem_a, 32'h0);
      chk("mid_rst_flags", {28'h0, mem_wr, busy, if_done, ls_done},
          32'h0);
      chk("mid_rst_data", if_data | ls_rdata | 32'(mem_dout), 32'h0);
      ls_req = 1'b0;
      tick();
      rst_in = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_in);
         chk("post_rst_idle",
             {29'h0, busy, mem_wr, ls_done}, 32'h0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the CPU core's fetch and load/store units, and directly upstream of the byte-wide RAM/IO bus.
- Accepts 32-bit-granular requests from instruction fetch (IF) and the load/store buffer (LS).
- Arbitrates between them and serializes each access into little-endian byte transactions on mem_a/mem_dout/mem_wr/mem_din.
- Returns assembled data with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, width of request and bus addresses.
- IO_HI, 2'b11, value of addr[17:16] marking the IO region.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  pause when low
- clr_in  input  1  pipeline flush (mispredict)
- if_req  input  1  fetch request, held until if_done
- if_addr  input  32  fetch address
- if_done  output  1  one-cycle pulse, if_data valid
- if_data  output  32  fetched word
- ls_req  input  1  load/store request, held until ls_done
- ls_we  input  1  1 = store
- ls_size  input  2  0 = byte, 1 = half, 2 = word; 3 = illegal
- ls_addr  input  32  access address
- ls_wdata  input  32  store data, low bytes used
- ls_done  output  1  one-cycle pulse
- ls_rdata  output  32  load data, zero-extended
- mem_din  input  8  RAM/IO read byte
- mem_dout  output  8  write byte
- mem_a  output  32  bus address
- mem_wr  output  1  1 = write
- io_buffer_full  input  1  UART tx buffer full
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_in. While rst_in is low, all outputs are 0, the state is IDLE, and the byte counter is 0.
- States: IDLE, IF_RD, LS_RD, LS_WR.
- IDLE arbitration:
  - ls_req has priority over if_req.
  - Accepting a request latches address, size (IF is always 4 bytes), write data and direction, sets cnt = 0, and enters IF_RD, LS_RD or LS_WR.
  - A request is never accepted in a cycle in which done is high. Requesters drop req the cycle after they see done.
- Timing (Et = accept edge + t; "cycle t" = cycle after Et; n = byte count):
  - Read:
    - mem_a = addr + i and mem_wr = 0 in cycle 1+i, for i = 0..n-1.
    - Byte i is captured from mem_din at E(2+i) into bits [8i+7:8i].
    - done is high in cycle n+1 with data valid: word read done in cycle 5, byte read in cycle 2.
    - Unused upper bytes are 0.
  - Write:
    - mem_a = addr + i, mem_dout = wdata[8i+7:8i], mem_wr = 1 in cycle 1+i.
    - done is high in cycle n+1; mem_wr = 0 in that cycle.
  - Return to IDLE on the done edge.
- Address increment is a full 32-bit add; no wrap handling beyond natural overflow.
- rdy_in low:
  - All state, counters and captured data are frozen.
  - mem_a is held.
  - mem_wr is forced to 0, so no write repeats.
  - Capture resumes on the first rdy_in-high edge. Data is consistent because mem_a was unchanged.
- clr_in, sampled at an edge with rdy_in high:
  - In IF_RD: abort to IDLE, no if_done, mem_wr = 0.
  - LS_RD / LS_WR continue to completion; stores are never torn.
  - In IDLE: if_req is ignored that cycle, even if LS is absent.
  - If an IF is aborted while ls_req is pending, LS is accepted on the next IDLE cycle.
- ls_size = 3: treated as word.
- Simultaneous if_req and ls_req in IDLE: LS served first; IF is served after ls_done if still requested.
- Reset mid-transfer: immediate IDLE, no done pulse, mem_wr = 0.

Optional Feature:
- Macro: MEM_CTRL_IO_STALL_EN.
- Defined: in LS_WR, a byte whose address has addr[17:16] == IO_HI is held (mem_wr = 0, cnt frozen, mem_a held) while io_buffer_full is high. It is written in the first cycle io_buffer_full is low.
- Undefined: io_buffer_full is ignored and writes proceed at one byte per cycle.

Test Plan:
- Reset low async mid-cycle -> all outputs 0 immediately. After release with no req, busy = 0 and mem_wr = 0.
- if_req, addr 0x100, RAM[0x100..0x103] = 13 00 00 93 -> mem_a 0x100..0x103 in cycles 1-4; if_done in cycle 5; if_data = 0x93000013.
- if_req and ls_req both at cycle 0; ls store word 0xDEADBEEF to 0x200 -> mem_wr cycles 1-4, bytes EF BE AD DE; ls_done cycle 5; IF accepted in cycle 6.
- if_req, then clr_in in cycle 2 -> no if_done, busy = 0 in cycle 3. A new if_req at 0x40 then completes normally.
- ls byte store 0x41 to 0x30000 with io_buffer_full high cycles 1-3 (macro defined) -> mem_wr = 0 cycles 1-3, mem_wr = 1 cycle 4, ls_done cycle 5. With macro undefined: write in cycle 1, done cycle 2.
- ls half load from 0x10, rdy_in low cycles 2-4 -> mem_wr never 1; ls_done 3 cycles late; ls_rdata = {16'h0, RAM[0x11], RAM[0x10]}.
